rx_frame_sync: RTL and testbench
================================

// Module: rx_frame_sync
// PURPOSE
//  Receive-side frame delineation and CRC check. Sits directly upstream of the RX
//  width converter and consumes the gearbox's DWIDTH-bit beat stream.
//  Finds frame boundaries by CRC hunting, and re-emits the beats with a 1-cycle delay,
//  marked with data_sof (first beat) and crc_good (last beat, CRC matched).
//  Frame layout (MSB first): [FW-1:FW-2] sync hdr, [FW-3:FW-4] meta,
//  [FW-5 -: PAYLOAD_WIDTH] payload, [CRC_WIDTH-1:0] CRC.
// PARAMETERS
//  DWIDTH          64      beat width; FRAME_WIDTH/DWIDTH = RATIO, power of 2, >= 1
//  FRAME_WIDTH     256     frame width incl. header and CRC
//  PAYLOAD_WIDTH   240     payload bits; CRC_WIDTH = FRAME_WIDTH-4-PAYLOAD_WIDTH
//  CRC_POLY        12'h80F CRC generator polynomial (implicit top bit), init all-ones, no final xor
//  LOCK_THRESH     8       consecutive CRC passes to enter LOCKED
//  UNLOCK_THRESH   4       consecutive CRC fails to drop to HUNT
// PORTS
//  clk         in   1       clock
//  rst         in   1       reset, synchronous, active-high
//  din         in   DWIDTH  beat from gearbox, first beat holds frame MSBs
//  din_valid   in   1       din qualifier; invalid cycles are ignored entirely
//  dout        out  DWIDTH  din delayed 1 cycle
//  dout_valid  out  1       din_valid delayed 1 cycle
//  data_sof    out  1       dout is beat 0 of a frame (LOCKED only)
//  crc_good    out  1       dout is last beat and frame CRC matched (LOCKED only)
//  frame_lock  out  1       state == LOCKED
//  crc_err     out  1       1-cycle pulse: LOCKED frame failed CRC
//  slip_cnt    out  16      saturating count of boundary slips since reset
// BEHAVIOUR
//  - Reset: all outputs 0, state HUNT, beat_cnt 0, CRC accum = all-ones, pass/fail cnt 0.
//  - Latency 1: every output is registered and aligned with dout/dout_valid.
//  - With din_valid=0: beat_cnt, CRC accum and counters hold; dout_valid=0, flags 0.
//  - beat_cnt counts 0..RATIO-1 on valid beats. Beat 0 reloads the accum from init.
//    CRC runs over all frame bits except the CRC field. On the last beat the final CRC is
//    computed combinationally and compared with din[CRC_WIDTH-1:0].
//  - HUNT: match -> pass_cnt++; at LOCK_THRESH -> LOCKED, fail_cnt=0.
//    mismatch -> pass_cnt=0, slip: the next valid beat is dropped from the count
//    (beat_cnt stays 0, accum not advanced), so the boundary moves +1 beat; slip_cnt++.
//    RATIO==1: no slip, only pass counting.
//  - LOCKED: match -> fail_cnt=0. Mismatch -> crc_err pulse, fail_cnt++; at
//    UNLOCK_THRESH -> HUNT, pass_cnt=0. The transition takes effect for the next frame.
//  - data_sof/crc_good are forced 0 in HUNT. In LOCKED, crc_good=0 on a failed frame,
//    but data_sof is still asserted.
//  - RATIO==1: data_sof and crc_good can assert on the same beat.
//  - Reset mid-frame: the partial frame is discarded; restart in HUNT at beat 0.
//  - slip_cnt saturates at 16'hFFFF.
// STRUCTURE
//  - rifl_rx_pkg: sync_state_t {HUNT, LOCKED}, crc_step() function (DWIDTH-bit
//    parallel CRC update), CRC_INIT constant.
//  - Sub-module rx_crc_accum: holds the accum, has init/advance/last-beat controls,
//    and outputs the combinational crc_final.
//  - The top level holds beat_cnt, slip logic, the FSM, threshold counters and output regs.
// TESTING (DWIDTH=64, FRAME_WIDTH=256, RATIO=4)
//  1. Aligned stream of 10 good frames
//     -> frame_lock rises after the 8th frame's last beat.
//     -> frames 9 and 10 show data_sof on beat 0 and crc_good on beat 3, each 1 cycle after din.
//  2. Stream offset by 2 beats
//     -> 2 slips (slip_cnt=2), then lock after 8 further good frames.
//     -> data_sof lands on true frame beat 0.
//  3. Locked; corrupt one CRC bit in 1 frame
//     -> crc_err pulse once, crc_good=0 for that frame, frame_lock stays 1.
//  4. Locked; 4 consecutive bad frames
//     -> 4 crc_err pulses, frame_lock falls after the 4th.
//     -> data_sof/crc_good stay 0 until relock.
//  5. din_valid toggled 1-0-1 during good frames
//     -> same lock and flag results as the gapless stream; dout_valid mirrors din_valid delayed 1.
//  6. rst at beat 2 of a locked frame
//     -> next cycle all outputs 0, state HUNT; relocks after 8 good aligned frames.

Source files
------------

// File: rtl/rifl_rx_pkg.sv
// Shared types, constants and the parallel CRC update used by the RX frame sync.
package rifl_rx_pkg;

   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } sync_state_t;

   // CRC field width of the link frame; the top derives the same width from its
   // frame parameters and uses it to slice the received CRC field.
   localparam int CRC_WIDTH = 12;

   // Generator polynomial without its implicit top bit.
   localparam logic [CRC_WIDTH-1:0] CRC_POLY_DEFAULT = 12'h80F;

   // Accumulator seed at the start of every frame; no final xor is applied.
   localparam logic [CRC_WIDTH-1:0] CRC_INIT = '1;

   // Widest beat the step function can absorb in one call.
   localparam int STEP_MAX = 256;

   // Parallel CRC update, MSB first. Data is left-aligned in a STEP_MAX-bit word
   // and only the top nbits are consumed, so one function serves both full beats
   // and the last beat that stops short of the CRC field. nbits is a constant at
   // every call site, so the loop unrolls into a pure xor network.
   function automatic logic [CRC_WIDTH-1:0] crc_step(
      input logic [CRC_WIDTH-1:0] crc,
      input logic [CRC_WIDTH-1:0] poly,
      input logic [STEP_MAX-1:0]  data,
      input int                   nbits
   );
      logic [CRC_WIDTH-1:0] c;
      logic                 fb;
      c = crc;
      for (int i = 0; i < STEP_MAX; i++) begin
         if (i < nbits) begin
            fb = c[CRC_WIDTH-1] ^ data[STEP_MAX-1-i];
            c  = {c[CRC_WIDTH-2:0], 1'b0};
            if (fb) begin
               c = c ^ poly;
            end
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/rx_crc_accum.sv
// Running CRC over the beats of one frame. The registered accumulator holds the
// CRC of all beats absorbed so far; crc_final is the combinational CRC of the
// whole frame including the current (last) beat, stopping before the CRC field.
module rx_crc_accum
   import rifl_rx_pkg::*;
#(
   parameter int                   DWIDTH   = 64,
   parameter logic [CRC_WIDTH-1:0] CRC_POLY = CRC_POLY_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 init,
   input  logic                 advance,
   input  logic                 last,
   input  logic [DWIDTH-1:0]    din,
   output logic [CRC_WIDTH-1:0] crc_final
);

   logic [CRC_WIDTH-1:0] accum_reg;
   logic [CRC_WIDTH-1:0] base;
   logic [STEP_MAX-1:0]  data_aligned;

   // Beat 0 starts from the seed rather than whatever the previous frame left.
   assign base = init ? CRC_INIT : accum_reg;

   // Left-align the beat so the step function sees the beat MSB first.
   always_comb begin
      data_aligned = '0;
      data_aligned[STEP_MAX-1 -: DWIDTH] = din;
   end

   // The last beat only contributes the bits above the CRC field.
   assign crc_final = crc_step(base, CRC_POLY, data_aligned, DWIDTH - CRC_WIDTH);

   // Absorb a counted beat; after the last beat park the accumulator at the seed.
   always_ff @(posedge clk) begin
      if (rst) begin
         accum_reg <= CRC_INIT;
      end else if (advance) begin
         if (last) begin
            accum_reg <= CRC_INIT;
         end else begin
            accum_reg <= crc_step(base, CRC_POLY, data_aligned, DWIDTH);
         end
      end
   end

endmodule

// File: rtl/rx_frame_sync.sv
// Receive frame delineation: hunts for the frame boundary by checking the CRC at
// every assumed frame end, slipping one beat on each miss, and once locked marks
// the start and the CRC-good end of each frame on a 1-cycle delayed beat stream.
module rx_frame_sync
   import rifl_rx_pkg::*;
#(
   parameter int                   DWIDTH        = 64,
   parameter int                   FRAME_WIDTH   = 256,
   parameter int                   PAYLOAD_WIDTH = 240,
   parameter logic [CRC_WIDTH-1:0] CRC_POLY      = CRC_POLY_DEFAULT,
   parameter int                   LOCK_THRESH   = 8,
   parameter int                   UNLOCK_THRESH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DWIDTH-1:0] din,
   input  logic              din_valid,
   output logic [DWIDTH-1:0] dout,
   output logic              dout_valid,
   output logic              data_sof,
   output logic              crc_good,
   output logic              frame_lock,
   output logic              crc_err,
   output logic [15:0]       slip_cnt
);

   localparam int RATIO  = FRAME_WIDTH / DWIDTH;
   localparam int CRC_W  = FRAME_WIDTH - 4 - PAYLOAD_WIDTH;
   localparam int BCW    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int PASS_W = $clog2(LOCK_THRESH + 1);
   localparam int FAIL_W = $clog2(UNLOCK_THRESH + 1);

   localparam logic [BCW-1:0] LAST_BEAT = BCW'(RATIO - 1);
   localparam logic [0:0]     ST_HUNT   = HUNT;
   localparam logic [0:0]     ST_LOCKED = LOCKED;

   // Frame tracking state
   logic [BCW-1:0]    beat_cnt_reg,     beat_cnt_next;
   logic              slip_pending_reg, slip_pending_next;
   logic [0:0]        state_reg,        state_next;
   logic [PASS_W-1:0] pass_cnt_reg,     pass_cnt_next;
   logic [FAIL_W-1:0] fail_cnt_reg,     fail_cnt_next;
   logic [15:0]       slip_cnt_reg,     slip_cnt_next;

   // Registered outputs
   logic [DWIDTH-1:0] dout_reg;
   logic              dout_valid_reg;
   logic              data_sof_reg,     data_sof_next;
   logic              crc_good_reg,     crc_good_next;
   logic              crc_err_reg,      crc_err_next;
   logic              frame_lock_reg;

   // CRC interface
   logic                 is_first;
   logic                 is_last;
   logic                 crc_init;
   logic                 crc_adv;
   logic [CRC_WIDTH-1:0] crc_final;
   logic [CRC_WIDTH-1:0] crc_field;
   logic                 crc_match;

   assign is_first  = (beat_cnt_reg == '0);
   assign is_last   = (beat_cnt_reg == LAST_BEAT);
   assign crc_field = CRC_WIDTH'(din[CRC_W-1:0]);
   assign crc_match = (crc_final == crc_field);

   rx_crc_accum #(
      .DWIDTH   (DWIDTH),
      .CRC_POLY (CRC_POLY)
   ) u_crc (
      .clk       (clk),
      .rst       (rst),
      .init      (crc_init),
      .advance   (crc_adv),
      .last      (is_last),
      .din       (din),
      .crc_final (crc_final)
   );

   // Beat counting, slip handling, hunt/lock FSM and per-beat flag decisions.
   always_comb begin
      beat_cnt_next     = beat_cnt_reg;
      slip_pending_next = slip_pending_reg;
      state_next        = state_reg;
      pass_cnt_next     = pass_cnt_reg;
      fail_cnt_next     = fail_cnt_reg;
      slip_cnt_next     = slip_cnt_reg;
      data_sof_next     = 1'b0;
      crc_good_next     = 1'b0;
      crc_err_next      = 1'b0;
      crc_init          = 1'b0;
      crc_adv           = 1'b0;

      if (din_valid) begin
         if (slip_pending_reg) begin
            // The swallowed beat moves the assumed boundary one beat later.
            slip_pending_next = 1'b0;
         end else begin
            crc_adv       = 1'b1;
            crc_init      = is_first;
            beat_cnt_next = is_last ? '0 : beat_cnt_reg + BCW'(1);

            if (state_reg == ST_LOCKED && is_first) begin
               data_sof_next = 1'b1;
            end

            if (is_last) begin
               if (state_reg == ST_HUNT) begin
                  if (crc_match) begin
                     if (pass_cnt_reg == PASS_W'(LOCK_THRESH - 1)) begin
                        state_next    = ST_LOCKED;
                        pass_cnt_next = '0;
                        fail_cnt_next = '0;
                     end else begin
                        pass_cnt_next = pass_cnt_reg + PASS_W'(1);
                     end
                  end else begin
                     pass_cnt_next = '0;
                     // With one beat per frame every beat is a boundary: nothing to slip.
                     if (RATIO > 1) begin
                        slip_pending_next = 1'b1;
                        if (slip_cnt_reg != 16'hFFFF) begin
                           slip_cnt_next = slip_cnt_reg + 16'd1;
                        end
                     end
                  end
               end else begin
                  if (crc_match) begin
                     fail_cnt_next = '0;
                     crc_good_next = 1'b1;
                  end else begin
                     crc_err_next = 1'b1;
                     if (fail_cnt_reg == FAIL_W'(UNLOCK_THRESH - 1)) begin
                        state_next    = ST_HUNT;
                        pass_cnt_next = '0;
                        fail_cnt_next = '0;
                     end else begin
                        fail_cnt_next = fail_cnt_reg + FAIL_W'(1);
                     end
                  end
               end
            end
         end
      end
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_reg     <= '0;
         slip_pending_reg <= 1'b0;
         state_reg        <= ST_HUNT;
         pass_cnt_reg     <= '0;
         fail_cnt_reg     <= '0;
         slip_cnt_reg     <= '0;
      end else begin
         beat_cnt_reg     <= beat_cnt_next;
         slip_pending_reg <= slip_pending_next;
         state_reg        <= state_next;
         pass_cnt_reg     <= pass_cnt_next;
         fail_cnt_reg     <= fail_cnt_next;
         slip_cnt_reg     <= slip_cnt_next;
      end
   end

   // Output stage: beat and its flags leave together one cycle after din;
   // frame_lock reports the state resulting from the beat on dout.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_reg       <= '0;
         dout_valid_reg <= 1'b0;
         data_sof_reg   <= 1'b0;
         crc_good_reg   <= 1'b0;
         crc_err_reg    <= 1'b0;
         frame_lock_reg <= 1'b0;
      end else begin
         dout_reg       <= din;
         dout_valid_reg <= din_valid;
         data_sof_reg   <= data_sof_next;
         crc_good_reg   <= crc_good_next;
         crc_err_reg    <= crc_err_next;
         frame_lock_reg <= (state_next == ST_LOCKED);
      end
   end

   assign dout       = dout_reg;
   assign dout_valid = dout_valid_reg;
   assign data_sof   = data_sof_reg;
   assign crc_good   = crc_good_reg;
   assign crc_err    = crc_err_reg;
   assign frame_lock = frame_lock_reg;
   assign slip_cnt   = slip_cnt_reg;

endmodule

// File: tb/tb_rx_frame_sync.sv
// Self-checking bench for rx_frame_sync with 64-bit beats and 256-bit frames.
module tb_rx_frame_sync;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] din;
   logic        din_valid;
   logic [63:0] dout;
   logic        dout_valid;
   logic        data_sof;
   logic        crc_good;
   logic        frame_lock;
   logic        crc_err;
   logic [15:0] slip_cnt;

   rx_frame_sync dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .dout       (dout),
      .dout_valid (dout_valid),
      .data_sof   (data_sof),
      .crc_good   (crc_good),
      .frame_lock (frame_lock),
      .crc_err    (crc_err),
      .slip_cnt   (slip_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] d;
      logic        v;
      logic        sof;
      logic        good;
      logic        err;
      logic        lock;
   } exp_t;

   // One frame of stimulus with the flags the frame must produce.
   typedef struct packed {
      logic rst_before;
      logic bad;
      logic gaps;
      logic sof;
      logic good;
      logic err;
      logic lock_in;
      logic lock_out;
   } frame_vec_t;

   exp_t       sb[$];
   frame_vec_t tbl[$];
   int         errors = 0;
   int         checks = 0;
   int         beat_no = 0;
   string      tag = "reset";

   // Bit-serial reference CRC over the whole frame above the CRC field.
   function automatic logic [11:0] ref_crc(input logic [255:0] f);
      logic [11:0] c;
      logic        fb;
      c = 12'hFFF;
      for (int i = 255; i >= 12; i--) begin
         fb = c[11] ^ f[i];
         c  = {c[10:0], 1'b0};
         if (fb) c = c ^ 12'h80F;
      end
      return c;
   endfunction

   function automatic logic [255:0] make_frame(input logic bad);
      logic [255:0] f;
      for (int k = 0; k < 8; k++) f[32*k +: 32] = $urandom;
      f[255:252] = 4'hA;
      f[11:0]    = ref_crc(f) ^ (bad ? 12'h010 : 12'h000);
      return f;
   endfunction

   function automatic frame_vec_t vec(input logic rb, input logic bad, input logic gaps,
                                      input logic sof, input logic good, input logic err,
                                      input logic lin, input logic lout);
      frame_vec_t v;
      v = {rb, bad, gaps, sof, good, err, lin, lout};
      return v;
   endfunction

   function automatic exp_t mk_exp(input logic [63:0] d, input logic v, input logic sof,
                                   input logic good, input logic err, input logic lock);
      exp_t e;
      e = {d, v, sof, good, err, lock};
      return e;
   endfunction

   task automatic check_out();
      exp_t e;
      exp_t a;
      e = sb.pop_front();
      a = {dout, dout_valid, data_sof, crc_good, crc_err, frame_lock};
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s beat %0d: got d=%h v=%b sof=%b good=%b err=%b lock=%b want d=%h v=%b sof=%b good=%b err=%b lock=%b",
                  tag, beat_no, a.d, a.v, a.sof, a.good, a.err, a.lock,
                  e.d, e.v, e.sof, e.good, e.err, e.lock);
      end else begin
         $display("%s beat %0d: d=%h v=%b sof=%b good=%b err=%b lock=%b ok",
                  tag, beat_no, a.d, a.v, a.sof, a.good, a.err, a.lock);
      end
      beat_no++;
   endtask

   // Drive one cycle, queue its expected output, sample 1 time unit after the edge.
   task automatic step(input logic [63:0] d, input logic v, input logic r, input exp_t e);
      din       = d;
      din_valid = v;
      rst       = r;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic do_reset();
      logic [63:0] j;
      for (int i = 0; i < 2; i++) begin
         j = {$urandom, $urandom};
         step(j, 1'b1, 1'b1, '0);
      end
   endtask

   task automatic send_frame(input logic [255:0] f, input frame_vec_t v);
      logic [63:0] d;
      logic [63:0] j;
      for (int b = 0; b < 4; b++) begin
         d = f[255-64*b -: 64];
         if (v.gaps && (b == 1 || b == 3)) begin
            j = {$urandom, $urandom};
            step(j, 1'b0, 1'b0, mk_exp(j, 1'b0, 1'b0, 1'b0, 1'b0, v.lock_in));
         end
         step(d, 1'b1, 1'b0,
              mk_exp(d, 1'b1, v.sof && b == 0, v.good && b == 3, v.err && b == 3,
                     (b == 3) ? v.lock_out : v.lock_in));
      end
   endtask

   task automatic check_slips(input logic [15:0] want);
      checks++;
      if (slip_cnt !== want) begin
         errors++;
         $display("FAIL %s slip_cnt: got %0d want %0d", tag, slip_cnt, want);
      end else begin
         $display("%s slip_cnt=%0d ok", tag, slip_cnt);
      end
   endtask

   initial begin
      logic [255:0] f;
      logic [63:0]  d;

      rst       = 1'b1;
      din       = '0;
      din_valid = 1'b0;

      // Aligned good frames: lock after the 8th, flags from the 9th.
      for (int i = 0; i < 10; i++)
         tbl.push_back(vec(i == 0, 1'b0, 1'b0, i >= 8, i >= 8, 1'b0, i >= 8, i >= 7));
      // One corrupted frame while locked, then a good one.
      tbl.push_back(vec(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
      tbl.push_back(vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
      // Four bad frames drop lock on the 4th; eight good frames relock.
      for (int k = 0; k < 4; k++)
         tbl.push_back(vec(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, k < 3));
      for (int k = 0; k < 8; k++)
         tbl.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, k == 7));
      tbl.push_back(vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
      // Same as the aligned run but with 1-0-1 valid gaps inside each frame.
      for (int i = 0; i < 10; i++)
         tbl.push_back(vec(i == 0, 1'b0, 1'b1, i >= 8, i >= 8, 1'b0, i >= 8, i >= 7));

      for (int n = 0; n < tbl.size(); n++) begin
         if (tbl[n].rst_before) begin
            tag = "reset";
            do_reset();
            check_slips(16'd0);
         end
         tag = tbl[n].gaps ? "gapped" : (tbl[n].bad ? "bad_frame" : "good_frame");
         send_frame(make_frame(tbl[n].bad), tbl[n]);
      end
      tag = "after_table";
      check_slips(16'd0);

      // Reset on beat 2 of a locked frame: outputs clear next cycle, then relock.
      tag = "rst_mid";
      f = make_frame(1'b0);
      d = f[255:192];
      step(d, 1'b1, 1'b0, mk_exp(d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
      d = f[191:128];
      step(d, 1'b1, 1'b0, mk_exp(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      d = f[127:64];
      step(d, 1'b1, 1'b1, '0);
      check_slips(16'd0);
      tag = "relock";
      for (int k = 0; k < 9; k++)
         send_frame(make_frame(1'b0),
                    vec(1'b0, 1'b0, 1'b0, k == 8, k == 8, 1'b0, k == 8, k >= 7));

      // Stream starting two beats into a frame: two slips, then 8 aligned good frames lock.
      tag = "reset";
      do_reset();
      tag = "offset";
      f = make_frame(1'b0);
      d = f[127:64];
      step(d, 1'b1, 1'b0, mk_exp(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      d = f[63:0];
      step(d, 1'b1, 1'b0, mk_exp(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 11; i++)
         send_frame(make_frame(1'b0),
                    vec(1'b0, 1'b0, 1'b0, i == 10, i == 10, 1'b0, i == 10, i >= 9));
      check_slips(16'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
